imem_fetch_ctrl: RTL

//  Instruction fetch sequencer for the combinational instruction ROM (word-indexed, IMEM_SIZE words).

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_buffer.sv | 52 +++++
 rtl/imem_fetch_ctrl.sv | 80 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch sequencer: FSM states and FIFO entry layout.
package fetch_pkg;

  localparam int unsigned InstW = 32;

  typedef enum logic [1:0] {IDLE, FETCH, DONE} fetch_state_t;

  typedef struct packed {
    logic [31:0]      pc;
    logic [InstW-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small power-of-two FIFO holding fetched {pc, inst} entries; flush wins over push.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned CntW  = $clog2(Depth) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  fetch_entry_t    wdata,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count,
  output fetch_entry_t    head
);

  localparam int unsigned PtrW = $clog2(Depth);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] rd_q, wr_q;
  logic [CntW-1:0] cnt_q;
  logic            pop_ok, push_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CntW'(Depth));
  assign count   = cnt_q;
  assign pop_ok  = pop && !empty;
  // When full, a same-cycle pop frees the head slot that wr_q points at.
  assign push_ok = push && !flush && (!full || pop_ok);
  assign head    = empty ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      if (push_ok && !pop_ok)      cnt_q <= cnt_q + 1'b1;
      else if (pop_ok && !push_ok) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: walks the PC through the ROM and queues {pc, inst} for decode.
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned IMEM_LEN  = InstW,
  parameter int unsigned IMEM_SIZE = 10,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  output logic [31:0]         imem_addr,
  input  logic [IMEM_LEN-1:0] imem_data,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [IMEM_LEN-1:0] inst_data,
  output logic [31:0]         inst_pc,
  output logic                busy,
  output logic                done
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH) + 1;

  fetch_state_t    state_q;
  logic [31:0]     pc_q;
  logic            in_range, push, pop, full, empty;
  logic [CntW-1:0] count;
  fetch_entry_t    wdata, head;

  assign imem_addr  = {2'b00, pc_q[31:2]};
  assign in_range   = imem_addr < 32'(IMEM_SIZE);
  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready;
  assign push       = !redirect_valid && (state_q == FETCH) && in_range && (!full || pop);
  assign wdata      = '{pc: pc_q, inst: imem_data};
  assign inst_data  = head.inst;
  assign inst_pc    = head.pc;
  assign busy       = (state_q == FETCH);
  assign done       = (state_q == DONE) && empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= 32'(RESET_PC);
    end else if (redirect_valid) begin
      state_q <= FETCH;
      pc_q    <= redirect_pc & ~32'h3;
    end else begin
      unique case (state_q)
        IDLE:  if (start) state_q <= FETCH;
        FETCH: begin
          if (!in_range) state_q <= DONE;
          else if (push) pc_q    <= pc_q + 32'd4;
        end
        DONE:    ;
        default: state_q <= IDLE;
      endcase
    end
  end

  fetch_buffer #(
    .Depth (BUF_DEPTH),
    .CntW  (CntW)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wdata),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );

endmodule
